// File: rtl/if_prefetch_unit_pkg.sv
// Shared types and defaults for the instruction-fetch prefetch unit.
package if_prefetch_unit_pkg;
  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    FLUSH = 2'd2
  } pf_state_e;

  localparam logic [31:0] NOP_INST     = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam int          DEPTH_DEF    = 4;
endpackage

// File: rtl/if_fetch_fifo.sv
// Circular buffer with push/pop/clear; clear wins over push and pop.
module if_fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 64,
  localparam int CW   = $clog2(DEPTH + 1),
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);
  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic          do_push, do_pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty && !clear;
  assign do_push = push && (!full || do_pop) && !clear;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= nxt(wr_ptr);
      if (do_pop)  rd_ptr <= nxt(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage is never reset; validity comes from the pointers alone.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end
endmodule

// File: rtl/if_prefetch_unit.sv
// IF-stage prefetcher: in-order IMEM fetch, PC-tagged prefetch queue, redirect flush.
module if_prefetch_unit
  import if_prefetch_unit_pkg::*;
#(
  parameter int                 DWIDTH   = 32,
  parameter int                 IWIDTH   = 32,
  parameter int                 DEPTH    = DEPTH_DEF,
  parameter logic [DWIDTH-1:0]  RESET_PC = DWIDTH'(RESET_PC_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req_valid,
  output logic [DWIDTH-1:0] imem_req_addr,
  input  logic              imem_req_ready,
  input  logic              imem_rsp_valid,
  input  logic [IWIDTH-1:0] imem_rsp_inst,
  input  logic              redirect_valid,
  input  logic [DWIDTH-1:0] redirect_pc,
  input  logic              stall,
  output logic              if_valid,
  output logic [IWIDTH-1:0] if_inst,
  output logic [DWIDTH-1:0] if_pc
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int QW = IWIDTH + DWIDTH;

  pf_state_e         state;
  logic [DWIDTH-1:0] fetch_pc;
  logic [CW-1:0]     outstanding, discard, out_net;
  logic [CW:0]       inflight;
  logic              req_hs, rsp_acc, q_push, q_pop;

  logic [QW-1:0]     q_rdata;
  logic [CW-1:0]     q_count, tag_count;
  logic              q_full, q_empty, tag_full, tag_empty;
  logic [DWIDTH-1:0] tag_pc;
  logic              unused_ok;

  // Queue slots are reserved for every in-flight request, so the queue cannot overflow.
  assign inflight       = {1'b0, q_count} + {1'b0, outstanding};
  assign imem_req_valid = (state == FETCH) && (inflight < (CW+1)'(DEPTH)) && !redirect_valid;
  assign imem_req_addr  = fetch_pc;
  assign req_hs         = imem_req_valid && imem_req_ready;
  assign rsp_acc        = imem_rsp_valid && (outstanding != '0);
  assign out_net        = outstanding - CW'(rsp_acc);
  assign q_push         = (state == FETCH) && rsp_acc && !redirect_valid;
  assign q_pop          = if_valid && !stall && !redirect_valid;

  assign if_valid = !q_empty;
  assign if_inst  = q_empty ? IWIDTH'(NOP_INST) : q_rdata[IWIDTH-1:0];
  assign if_pc    = q_empty ? RESET_PC : q_rdata[IWIDTH +: DWIDTH];

  assign unused_ok = ^{tag_count, tag_full, tag_empty, q_full, redirect_pc[1:0]};

  // PC tags of requests in flight, returned in the same order as IMEM responses.
  if_fetch_fifo #(.DEPTH(DEPTH), .W(DWIDTH)) u_tag_fifo (
    .clk   (clk),
    .rst   (rst),
    .clear (redirect_valid),
    .push  (req_hs),
    .pop   (q_push),
    .wdata (fetch_pc),
    .rdata (tag_pc),
    .count (tag_count),
    .full  (tag_full),
    .empty (tag_empty)
  );

  if_fetch_fifo #(.DEPTH(DEPTH), .W(QW)) u_inst_q (
    .clk   (clk),
    .rst   (rst),
    .clear (redirect_valid),
    .push  (q_push),
    .pop   (q_pop),
    .wdata ({tag_pc, imem_rsp_inst}),
    .rdata (q_rdata),
    .count (q_count),
    .full  (q_full),
    .empty (q_empty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= BOOT;
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      outstanding <= outstanding + CW'(req_hs) - CW'(rsp_acc);
      if (redirect_valid) begin
        // Responses still in flight belong to the old path and must be dropped.
        fetch_pc <= {redirect_pc[DWIDTH-1:2], 2'b00};
        discard  <= out_net;
        state    <= (out_net != '0) ? FLUSH : FETCH;
      end else begin
        if (req_hs) fetch_pc <= fetch_pc + DWIDTH'(4);
        case (state)
          BOOT:  state <= FETCH;
          FLUSH: begin
            if (rsp_acc) begin
              discard <= discard - 1'b1;
              if (discard <= CW'(1)) state <= FETCH;
            end else if (discard == '0) begin
              state <= FETCH;
            end
          end
          default: state <= state;
        endcase
      end
    end
  end
endmodule
